// File: rtl/wavegen_poly_if.sv
// Config/tick/sample bundle between the voice controller, the wavegen_poly oscillator bank and the mixer.
interface wavegen_poly_if #(
   parameter int unsigned WAVE_DEPTH  = 8,
   parameter int unsigned PHASE_DEPTH = 16,
   parameter int unsigned CH_BITS     = 2
);
   logic                   CfgWrite;
   logic [CH_BITS-1:0]     CfgChan;
   logic [PHASE_DEPTH-1:0] CfgIncr;
   logic [1:0]             CfgType;
   logic [WAVE_DEPTH-1:0]  CfgDuty;
   logic                   CfgGate;
   logic                   Tick;
   logic                   Busy;
   logic                   SampleValid;
   logic [CH_BITS-1:0]     SampleChan;
   logic [WAVE_DEPTH-1:0]  Sample;
   logic                   Overrun;

   modport master (
      output CfgWrite, CfgChan, CfgIncr, CfgType, CfgDuty, CfgGate, Tick,
      input  Busy, SampleValid, SampleChan, Sample, Overrun
   );

   modport slave (
      input  CfgWrite, CfgChan, CfgIncr, CfgType, CfgDuty, CfgGate, Tick,
      output Busy, SampleValid, SampleChan, Sample, Overrun
   );
endinterface

// File: rtl/wavegen_poly.sv
// Time-multiplexed oscillator bank: one channel evaluated per cycle during a Tick-started sweep.
// Optional WAVEGEN_NOISE_EN makes type 11 a per-channel 16-bit LFSR noise source (else type 11 outputs MID).
module wavegen_poly #(
   parameter int unsigned WAVE_DEPTH  = 8,
   parameter int unsigned PHASE_DEPTH = 16,
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned CH_BITS     = 2
) (
   input logic          Clock,
   input logic          Reset,
   wavegen_poly_if.slave bus
);
   localparam logic [WAVE_DEPTH-1:0] MID  = WAVE_DEPTH'(1) << (WAVE_DEPTH - 1);
   localparam logic [WAVE_DEPTH-1:0] MAX  = '1;
   localparam logic [CH_BITS-1:0]    LAST = CH_BITS'(CHANNELS - 1);

   typedef enum logic {IDLE, SCAN} state_t;
   state_t state, state_next;

   logic [CH_BITS-1:0]     ch;
   logic                   busy;
   logic [PHASE_DEPTH-1:0] phase [CHANNELS];
   logic [PHASE_DEPTH-1:0] incr  [CHANNELS];
   logic [1:0]             wtype [CHANNELS];
   logic [WAVE_DEPTH-1:0]  duty  [CHANNELS];
   logic                   gate  [CHANNELS];

   logic                   sample_valid;
   logic [CH_BITS-1:0]     sample_chan;
   logic [WAVE_DEPTH-1:0]  sample;
   logic                   overrun;

   logic [PHASE_DEPTH-1:0] sel_phase;
   logic [1:0]             sel_type;
   logic [WAVE_DEPTH-1:0]  sel_duty;
   logic                   sel_gate;
   logic [WAVE_DEPTH-1:0]  p, tri_t, wave;
`ifdef WAVEGEN_NOISE_EN
   logic [15:0]            lfsr [CHANNELS];
   logic [15:0]            sel_lfsr;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      case (state)
         IDLE: if (bus.Tick) state_next = SCAN;
         SCAN: begin
            busy = 1'b1;
            if (ch == LAST) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Channel select is a compare-mux so a non-power-of-two CHANNELS never indexes past the arrays.
   always_comb begin
      sel_phase = '0;
      sel_type  = 2'b00;
      sel_duty  = MID;
      sel_gate  = 1'b0;
`ifdef WAVEGEN_NOISE_EN
      sel_lfsr  = '0;
`endif
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (ch == CH_BITS'(i)) begin
            sel_phase = phase[i];
            sel_type  = wtype[i];
            sel_duty  = duty[i];
            sel_gate  = gate[i];
`ifdef WAVEGEN_NOISE_EN
            sel_lfsr  = lfsr[i];
`endif
         end
      end
   end

   always_comb begin
      p     = sel_phase[PHASE_DEPTH-1 -: WAVE_DEPTH];
      tri_t = {p[WAVE_DEPTH-2:0], 1'b0};
      wave  = MID;
      if (sel_gate) begin
         case (sel_type)
            2'b00:   wave = p;
            2'b01:   wave = (p < sel_duty) ? MAX : '0;
            2'b10:   wave = p[WAVE_DEPTH-1] ? (MAX - tri_t) : tri_t;
`ifdef WAVEGEN_NOISE_EN
            default: wave = sel_lfsr[15 -: WAVE_DEPTH];
`else
            default: wave = MID;
`endif
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            phase[i] <= '0;
            incr[i]  <= '0;
            wtype[i] <= 2'b00;
            duty[i]  <= MID;
            gate[i]  <= 1'b0;
`ifdef WAVEGEN_NOISE_EN
            lfsr[i]  <= 16'hACE1;
`endif
         end
         ch           <= '0;
         sample_valid <= 1'b0;
         sample_chan  <= '0;
         sample       <= '0;
         overrun      <= 1'b0;
      end else begin
         sample_valid <= busy;
         if (busy) begin
            sample_chan <= ch;
            sample      <= wave;
            ch          <= (ch == LAST) ? '0 : ch + 1'b1;
         end
         if (bus.Tick && busy) overrun <= 1'b1;
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (busy && ch == CH_BITS'(i)) begin
               phase[i] <= gate[i] ? phase[i] + incr[i] : '0;
`ifdef WAVEGEN_NOISE_EN
               if (gate[i])
                  lfsr[i] <= {lfsr[i][14:0], lfsr[i][15] ^ lfsr[i][13] ^ lfsr[i][12] ^ lfsr[i][10]};
`endif
            end
            // Config registers are read by the evaluation above, so a same-cycle write lands after it.
            if (bus.CfgWrite && bus.CfgChan == CH_BITS'(i)) begin
               incr[i]  <= bus.CfgIncr;
               wtype[i] <= bus.CfgType;
               duty[i]  <= bus.CfgDuty;
               gate[i]  <= bus.CfgGate;
            end
         end
      end
   end

   assign bus.Busy        = busy;
   assign bus.SampleValid = sample_valid;
   assign bus.SampleChan  = sample_chan;
   assign bus.Sample      = sample;
   assign bus.Overrun     = overrun;
endmodule

// File: tb/tb_wavegen_poly.sv
// Bench for wavegen_poly: spec vector table, hand-written corner sequences, random sweeps vs an arithmetic model.
module tb_wavegen_poly;
   localparam int unsigned CH = 4;

   logic Clock;
   logic Reset;
   int   total;
   int   bad;

   wavegen_poly_if #(.WAVE_DEPTH(8), .PHASE_DEPTH(16), .CH_BITS(2)) bus ();

   wavegen_poly #(
      .WAVE_DEPTH(8), .PHASE_DEPTH(16), .CHANNELS(4), .CH_BITS(2)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .bus(bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   // Behavioural model state
   int unsigned m_phase [CH];
   int unsigned m_incr  [CH];
   int unsigned m_typ   [CH];
   int unsigned m_duty  [CH];
   bit          m_gate  [CH];
   logic [7:0]  got     [CH];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] model_eval(input int unsigned c);
      int unsigned pv = m_phase[c] / 256;
      int unsigned r;
      if (!m_gate[c]) begin
         m_phase[c] = 0;
         return 8'h80;
      end
      case (m_typ[c])
         0:       r = pv;
         1:       r = (pv < m_duty[c]) ? 255 : 0;
         2:       r = (pv < 128) ? 2 * pv : 511 - 2 * pv;
         default: r = 128;
      endcase
      m_phase[c] = (m_phase[c] + m_incr[c]) % 65536;
      return 8'(r);
   endfunction

   task automatic do_reset();
      @(negedge Clock);
      Reset = 1'b1;
      bus.Tick = 1'b0;
      bus.CfgWrite = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      for (int unsigned i = 0; i < CH; i++) begin
         m_phase[i] = 0; m_incr[i] = 0; m_typ[i] = 0; m_duty[i] = 128; m_gate[i] = 1'b0;
      end
   endtask

   task automatic drive_cfg(input int unsigned c, input int unsigned incr, input int unsigned typ,
                            input int unsigned duty, input bit g);
      bus.CfgWrite = 1'b1;
      bus.CfgChan  = 2'(c);
      bus.CfgIncr  = 16'(incr);
      bus.CfgType  = 2'(typ);
      bus.CfgDuty  = 8'(duty);
      bus.CfgGate  = g;
      m_incr[c] = incr % 65536; m_typ[c] = typ; m_duty[c] = duty; m_gate[c] = g;
   endtask

   task automatic cfg(input int unsigned c, input int unsigned incr, input int unsigned typ,
                      input int unsigned duty, input bit g);
      @(negedge Clock);
      drive_cfg(c, incr, typ, duty, g);
      @(negedge Clock);
      bus.CfgWrite = 1'b0;
   endtask

   // One Tick-started sweep; optionally writes a config during evaluation cycle wcyc.
   task automatic run_sweep(input bit wr, input int unsigned wcyc, input int unsigned wch,
                            input int unsigned wincr, input int unsigned wtyp,
                            input int unsigned wduty, input bit wgate);
      logic [7:0] exp_s [CH];
      @(negedge Clock);
      bus.Tick = 1'b1;
      for (int unsigned j = 0; j <= CH; j++) begin
         @(negedge Clock);
         bus.Tick = 1'b0;
         bus.CfgWrite = 1'b0;
         if (j < CH) begin
            check("busy", 32'(bus.Busy), 1);
            exp_s[j] = model_eval(j);
            if (wr && j == wcyc) drive_cfg(wch, wincr, wtyp, wduty, wgate);
         end else begin
            check("busy_end", 32'(bus.Busy), 0);
         end
         if (j > 0) begin
            check("valid", 32'(bus.SampleValid), 1);
            check("chan", 32'(bus.SampleChan), j - 1);
            check("sample", 32'(bus.Sample), 32'(exp_s[j-1]));
            got[j-1] = bus.Sample;
         end
      end
      @(negedge Clock);
      check("valid_after", 32'(bus.SampleValid), 0);
   endtask

   task automatic sweep();
      run_sweep(1'b0, 0, 0, 0, 0, 0, 1'b0);
   endtask

   typedef struct {
      logic [15:0]      incr;
      logic [1:0]       typ;
      logic [7:0]       duty;
      logic [3:0][7:0]  exp;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int nv;
      total = 0;
      bad   = 0;
      Reset = 1'b1;
      bus.Tick = 1'b0; bus.CfgWrite = 1'b0; bus.CfgChan = '0; bus.CfgIncr = '0;
      bus.CfgType = '0; bus.CfgDuty = '0; bus.CfgGate = 1'b0;

      vecs[0] = '{incr: 16'h0100, typ: 2'b00, duty: 8'h80, exp: {8'h03, 8'h02, 8'h01, 8'h00}};
      vecs[1] = '{incr: 16'hC000, typ: 2'b00, duty: 8'h80, exp: {8'h40, 8'h80, 8'hC0, 8'h00}};
      vecs[2] = '{incr: 16'h2000, typ: 2'b01, duty: 8'h40, exp: {8'h00, 8'h00, 8'hFF, 8'hFF}};
      vecs[3] = '{incr: 16'h4000, typ: 2'b10, duty: 8'h80, exp: {8'h7F, 8'hFF, 8'h80, 8'h00}};

      // Reset state
      do_reset();
      check("rst_busy",  32'(bus.Busy), 0);
      check("rst_valid", 32'(bus.SampleValid), 0);
      check("rst_chan",  32'(bus.SampleChan), 0);
      check("rst_sample",32'(bus.Sample), 0);
      check("rst_ovr",   32'(bus.Overrun), 0);

      // Spec waveform table on channel 0; ungated channels must read MID
      for (int v = 0; v < 4; v++) begin
         do_reset();
         cfg(0, vecs[v].incr, vecs[v].typ, vecs[v].duty, 1'b1);
         for (int k = 0; k < 4; k++) begin
            sweep();
            check($sformatf("vec%0d_s%0d", v, k), 32'(got[0]), 32'(vecs[v].exp[k]));
            check($sformatf("vec%0d_mid", v), 32'(got[1]), 32'h80);
         end
      end

      // Overrun: second Tick during sweep is dropped, exactly one set of samples
      do_reset();
      cfg(0, 16'h0100, 0, 8'h80, 1'b1);
      nv = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge Clock);
         if (bus.SampleValid) nv++;
         bus.Tick = (i == 0 || i == 2);
      end
      check("ovr_count", 32'(nv), 4);
      check("ovr_flag", 32'(bus.Overrun), 1);
      repeat (3) @(negedge Clock);
      check("ovr_sticky", 32'(bus.Overrun), 1);

      // Reset mid-sweep aborts output
      do_reset();
      check("ovr_cleared", 32'(bus.Overrun), 0);
      cfg(0, 16'h0100, 0, 8'h80, 1'b1);
      @(negedge Clock); bus.Tick = 1'b1;
      @(negedge Clock); bus.Tick = 1'b0;
      @(negedge Clock); Reset = 1'b1;
      @(negedge Clock); Reset = 1'b0;
      check("rstmid_valid", 32'(bus.SampleValid), 0);
      check("rstmid_busy", 32'(bus.Busy), 0);
      nv = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clock);
         if (bus.SampleValid) nv++;
      end
      check("rstmid_count", 32'(nv), 0);

      // Gate off forces MID and clears phase
      do_reset();
      cfg(0, 16'h1000, 0, 8'h80, 1'b1);
      sweep(); sweep();
      check("gate_run", 32'(got[0]), 32'h10);
      cfg(0, 16'h1000, 0, 8'h80, 1'b0);
      sweep();
      check("gate_off", 32'(got[0]), 32'h80);
      cfg(0, 16'h1000, 0, 8'h80, 1'b1);
      sweep();
      check("gate_restart", 32'(got[0]), 32'h00);

      // Write to the channel being evaluated uses old config this sweep
      cfg(2, 16'h1000, 0, 8'h80, 1'b1);
      sweep();
      run_sweep(1'b1, 2, 2, 16'h1000, 0, 8'h80, 1'b0);
      check("samecyc_old", 32'(got[2]), 32'h10);
      sweep();
      check("samecyc_new", 32'(got[2]), 32'h80);

      // Randomized sweeps against the model
      do_reset();
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 1) == 1)
            cfg($urandom_range(0, CH - 1), $urandom_range(0, 65535), $urandom_range(0, 3),
                $urandom_range(0, 255), $urandom_range(0, 3) != 0);
         run_sweep($urandom_range(0, 2) == 0, $urandom_range(0, CH - 1), $urandom_range(0, CH - 1),
                   $urandom_range(0, 65535), $urandom_range(0, 3), $urandom_range(0, 255),
                   $urandom_range(0, 3) != 0);
      end
      check("rand_ovr", 32'(bus.Overrun), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
